md_unit: RTL and testbench



---
 rtl/md_unit_if.sv | 26 ++
 rtl/md_unit.sv | 162 ++++++++++++++++
 tb/tb_md_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Execute-stage <-> md_unit bundle: request code/operands in, busy and HI/LO out.
// The flush wire exists only when MD_FLUSH_EN is defined.
interface md_unit_if;
  logic [2:0]  md_ctrl;
  logic        start;
  logic [31:0] data_a;
  logic [31:0] data_b;
`ifdef MD_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MD_FLUSH_EN
  modport master (output md_ctrl, start, data_a, data_b, flush,
                  input  busy, hi, lo);
  modport slave  (input  md_ctrl, start, data_a, data_b, flush,
                  output busy, hi, lo);
`else
  modport master (output md_ctrl, start, data_a, data_b,
                  input  busy, hi, lo);
  modport slave  (input  md_ctrl, start, data_a, data_b,
                  output busy, hi, lo);
`endif
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO and mthi/mtlo writes.
// Optional abort path enabled by defining MD_FLUSH_EN.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave md
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] pend_hi, pend_lo, pend_hi_next, pend_lo_next;
  logic [31:0] hi_q, lo_q, hi_next, lo_next;
  logic        busy_q;
  logic        flush_req;

`ifdef MD_FLUSH_EN
  assign flush_req = md.flush;
`else
  assign flush_req = 1'b0;
`endif

  logic [31:0] a, b;
  logic [63:0] mul_s, mul_u;
  logic [31:0] abs_a, abs_b, abs_b_safe, b_safe;
  logic [31:0] q_mag, r_mag, div_q, div_r, divu_q, divu_r;
  logic [31:0] res_hi, res_lo;

  assign a = md.data_a;
  assign b = md.data_b;

  always_comb begin
    mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u = {32'd0, a} * {32'd0, b};
  end

  // Signed divide goes through magnitudes so 8000_0000 / FFFF_FFFF falls out as
  // quotient 8000_0000, remainder 0 without a separate overflow case.
  always_comb begin
    b_safe     = (b == '0) ? 32'd1 : b;
    abs_a      = a[31] ? (~a + 32'd1) : a;
    abs_b      = b[31] ? (~b + 32'd1) : b;
    abs_b_safe = (b == '0) ? 32'd1 : abs_b;
    q_mag      = abs_a / abs_b_safe;
    r_mag      = abs_a % abs_b_safe;
    div_q      = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    div_r      = a[31] ? (~r_mag + 32'd1) : r_mag;
    divu_q     = a / b_safe;
    divu_r     = a % b_safe;
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (md.md_ctrl)
      OP_MULT:  {res_hi, res_lo} = mul_s;
      OP_MULTU: {res_hi, res_lo} = mul_u;
      OP_DIV: begin
        res_hi = (b == '0) ? a   : div_r;
        res_lo = (b == '0) ? '1  : div_q;
      end
      OP_DIVU: begin
        res_hi = (b == '0) ? a   : divu_r;
        res_lo = (b == '0) ? '1  : divu_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    hi_next      = hi_q;
    lo_next      = lo_q;
    case (state)
      IDLE: begin
        if (!flush_req) begin
          case (md.md_ctrl)
            OP_MULT, OP_MULTU: if (md.start) begin
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
              cnt_next     = 4'(MUL_CYCLES - 1);
              state_next   = MUL;
            end
            OP_DIV, OP_DIVU: if (md.start) begin
              pend_hi_next = res_hi;
              pend_lo_next = res_lo;
              cnt_next     = 4'(DIV_CYCLES - 1);
              state_next   = DIV;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (flush_req) begin
          state_next   = IDLE;
          cnt_next     = '0;
          pend_hi_next = '0;
          pend_lo_next = '0;
        end else if (cnt == '0) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      hi_q    <= hi_next;
      lo_q    <= lo_next;
      busy_q  <= (state_next != IDLE);
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

`ifndef SYNTHESIS
  // The hazard unit should never let these through; make it visible in simulation.
  always_ff @(posedge clk) begin
    if (reset && state != IDLE &&
        ((md.start && md.md_ctrl >= OP_MULT && md.md_ctrl <= OP_DIVU) ||
         md.md_ctrl == OP_MTHI || md.md_ctrl == OP_MTLO))
      $display("md_unit error: request md_ctrl=%0d issued while busy, ignored", md.md_ctrl);
  end
`endif

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (flush steps compile in with MD_FLUSH_EN).
module tb_md_unit;
  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  md_unit_if md ();

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.md_ctrl = op;
    md.start   = 1'b1;
    md.data_a  = a;
    md.data_b  = b;
    @(posedge clk);
    #1;
    md.md_ctrl = 3'b000;
    md.start   = 1'b0;
    md.data_a  = 32'hA5A5_5A5A;
    md.data_b  = 32'h0000_0000;
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    md.md_ctrl = op;
    md.data_a  = a;
    @(posedge clk);
    #1;
    md.md_ctrl = 3'b000;
  endtask

  // n busy cycles with HI/LO held, then busy low with the committed result.
  task automatic wait_op(input string tag, input int unsigned n,
                         input logic [31:0] oh, input logic [31:0] ol,
                         input logic [31:0] eh, input logic [31:0] el);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, {31'd0, md.busy}, 32'd1);
      chk({tag, " hi held"}, md.hi, oh);
      chk({tag, " lo held"}, md.lo, ol);
    end
    @(negedge clk);
    chk({tag, " busy done"}, {31'd0, md.busy}, 32'd0);
    chk({tag, " hi"}, md.hi, eh);
    chk({tag, " lo"}, md.lo, el);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    md.md_ctrl = 3'b000;
    md.start   = 1'b0;
    md.data_a  = '0;
    md.data_b  = '0;
`ifdef MD_FLUSH_EN
    md.flush   = 1'b0;
`endif
    #23;
    chk("reset busy", {31'd0, md.busy}, 32'd0);
    chk("reset hi", md.hi, 32'd0);
    chk("reset lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy", {31'd0, md.busy}, 32'd0);
    chk("idle hi", md.hi, 32'd0);
    chk("idle lo", md.lo, 32'd0);

    launch(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_op("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    launch(3'b010, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_op("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
    launch(3'b011, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_op("div", 10, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    launch(3'b100, 32'd100, 32'd0);
    wait_op("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFFF);
    launch(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op("divovf", 10, 32'd100, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // start with a non-arithmetic code does nothing
    launch(3'b111, 32'd9, 32'd9);
    @(negedge clk);
    chk("op7 busy", {31'd0, md.busy}, 32'd0);
    chk("op7 hi", md.hi, 32'd0);
    chk("op7 lo", md.lo, 32'h8000_0000);

    move_to(3'b101, 32'h1234_5678);
    @(negedge clk);
    chk("mthi hi", md.hi, 32'h1234_5678);
    chk("mthi busy", {31'd0, md.busy}, 32'd0);
    move_to(3'b110, 32'hAABB_CCDD);
    @(negedge clk);
    chk("mtlo lo", md.lo, 32'hAABB_CCDD);

    launch(3'b001, 32'd2, 32'd3);
    @(negedge clk);
    chk("mul23 busy1", {31'd0, md.busy}, 32'd1);
    md.md_ctrl = 3'b110;
    md.data_a  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    md.md_ctrl = 3'b000;
    wait_op("mul23", 4, 32'h1234_5678, 32'hAABB_CCDD, 32'd0, 32'd6);

    launch(3'b010, 32'd5, 32'd7);
    wait_op("b2b first", 5, 32'd0, 32'd6, 32'd0, 32'h23);
    md.md_ctrl = 3'b100;
    md.start   = 1'b1;
    md.data_a  = 32'd100;
    md.data_b  = 32'd7;
    @(posedge clk);
    #1;
    md.md_ctrl = 3'b000;
    md.start   = 1'b0;
    md.data_b  = 32'd0;
    wait_op("b2b second", 10, 32'd0, 32'h23, 32'd2, 32'hE);

`ifdef MD_FLUSH_EN
    launch(3'b011, 32'd1000, 32'd10);
    repeat (3) @(negedge clk);
    @(negedge clk);
    md.flush = 1'b1;
    @(posedge clk);
    #1;
    md.flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, md.busy}, 32'd0);
    chk("flush hi", md.hi, 32'd2);
    chk("flush lo", md.lo, 32'hE);
    launch(3'b001, 32'd4, 32'd4);
    repeat (4) @(negedge clk);
    @(negedge clk);
    md.flush = 1'b1;
    @(posedge clk);
    #1;
    md.flush = 1'b0;
    @(negedge clk);
    chk("flush commit busy", {31'd0, md.busy}, 32'd0);
    chk("flush commit hi", md.hi, 32'd2);
    chk("flush commit lo", md.lo, 32'hE);
`endif

    // asynchronous reset in the middle of an operation
    launch(3'b001, 32'd3, 32'd3);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst busy", {31'd0, md.busy}, 32'd0);
    chk("async rst hi", md.hi, 32'd0);
    chk("async rst lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post rst busy", {31'd0, md.busy}, 32'd0);
    chk("post rst hi", md.hi, 32'd0);
    chk("post rst lo", md.lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
